// File: rtl/game_flow_ctrl.sv
// Game flow FSM: IDLE/PLAY/CRASH/OVER sequencing, saturating score with registered BCD copy.
// Optional best-score register enabled by defining GAME_FLOW_HISCORE_EN.
module game_flow_ctrl #(
  parameter int unsigned CRASH_TICKS = 20,
  parameter int unsigned SCORE_MAX   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start_btn,
  input  logic        crash,
  input  logic        pass_mountain,
  input  logic        pass_lava,
  output logic [1:0]  state,
  output logic        running,
  output logic        game_over,
  output logic        move_en,
  output logic        blink,
  output logic [7:0]  score,
  output logic [11:0] score_bcd,
  output logic [7:0]  hiscore
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StCrash = 2'd2,
    StOver  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  score_q, score_d;
  logic [11:0] bcd_q, bcd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        blink_q, blink_d;
  logic        start_prev_q, start_prev_d;
  logic        start_edge;
  logic [8:0]  score_sum;

  function automatic logic [11:0] to_bcd(input logic [7:0] bin);
    logic [19:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8] >= 4'd5)  sh[11:8]  = sh[11:8] + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
    return sh[19:8];
  endfunction

  assign start_edge   = start_btn & ~start_prev_q;
  assign start_prev_d = start_btn;
  assign score_sum    = {1'b0, score_q} + {8'd0, pass_mountain} + {8'd0, pass_lava};
  assign bcd_d        = to_bcd(score_q);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StPlay;
          score_d = '0;
        end
      end
      StPlay: begin
        // A crash in the same cycle as a pass pulse discards the pass.
        if (crash) begin
          state_d = StCrash;
          cnt_d   = 8'(CRASH_TICKS);
          blink_d = 1'b1;
        end else if (score_sum > 9'(SCORE_MAX)) begin
          score_d = 8'(SCORE_MAX);
        end else begin
          score_d = score_sum[7:0];
        end
      end
      StCrash: begin
        if (tick) begin
          if (cnt_q <= 8'd1) begin
            state_d = StOver;
            cnt_d   = '0;
            blink_d = 1'b0;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            blink_d = ~blink_q;
          end
        end
      end
      StOver: begin
        if (start_edge) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      score_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      blink_q      <= 1'b0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      blink_q      <= blink_d;
      start_prev_q <= start_prev_d;
    end
  end

`ifdef GAME_FLOW_HISCORE_EN
  logic [7:0] hiscore_q, hiscore_d;

  always_comb begin
    hiscore_d = hiscore_q;
    if (state_q == StCrash && state_d == StOver && score_q > hiscore_q) hiscore_d = score_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hiscore_q <= '0;
    else       hiscore_q <= hiscore_d;
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

  assign state     = state_q;
  assign running   = (state_q == StPlay);
  assign game_over = (state_q == StCrash) || (state_q == StOver);
  assign move_en   = tick & running;
  assign blink     = blink_q;
  assign score     = score_q;
  assign score_bcd = bcd_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random traffic against a rule-level model.
module tb_game_flow_ctrl;

  localparam int CT   = 20;
  localparam int SMAX = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0, start_btn = 1'b0, crash = 1'b0;
  logic        pass_mountain = 1'b0, pass_lava = 1'b0;
  logic [1:0]  state;
  logic        running, game_over, move_en, blink;
  logic [7:0]  score, hiscore;
  logic [11:0] score_bcd;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_state, m_score, m_cnt, m_blink, m_prev, m_hi, m_bcd;

  game_flow_ctrl #(.CRASH_TICKS(CT), .SCORE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_btn(start_btn), .crash(crash),
    .pass_mountain(pass_mountain), .pass_lava(pass_lava), .state(state), .running(running),
    .game_over(game_over), .move_en(move_en), .blink(blink), .score(score),
    .score_bcd(score_bcd), .hiscore(hiscore)
  );

  always #5 clk = ~clk;

  function automatic int bcd_of(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int hi_expect(input int h);
`ifdef GAME_FLOW_HISCORE_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic reset_model();
    m_state = 0; m_score = 0; m_cnt = 0; m_blink = 0; m_prev = 1; m_hi = 0; m_bcd = 0;
  endtask

  task automatic model_step();
    int old_score;
    bit st_edge;
    old_score = m_score;
    st_edge   = start_btn && (m_prev == 0);
    case (m_state)
      0: if (st_edge) begin m_state = 1; m_score = 0; end
      1: begin
        if (crash) begin
          m_state = 2; m_cnt = CT; m_blink = 1;
        end else begin
          m_score = m_score + int'(pass_mountain) + int'(pass_lava);
          if (m_score > SMAX) m_score = SMAX;
        end
      end
      2: if (tick) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_state = 3; m_blink = 0;
          if (m_score > m_hi) m_hi = m_score;
        end else begin
          m_blink = 1 - m_blink;
        end
      end
      default: if (st_edge) m_state = 0;
    endcase
    m_bcd  = bcd_of(old_score);
    m_prev = int'(start_btn);
  endtask

  // One clock: model follows the DUT edge, then step 1 ns away from it.
  task automatic cycle();
    @(posedge clk);
    if (reset) reset_model();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    reset_model();
    n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (score !== 8'd0) $display("FAIL reset_score: got %0d want 0", score); else n_pass++;
    n_checks++; if (score_bcd !== 12'h000) $display("FAIL reset_bcd: got %h want 000", score_bcd); else n_pass++;
    n_checks++; if (blink !== 1'b0) $display("FAIL reset_blink: got %b want 0", blink); else n_pass++;
    n_checks++; if (hiscore !== 8'd0) $display("FAIL reset_hiscore: got %0d want 0", hiscore); else n_pass++;
    n_checks++; if (running !== 1'b0 || game_over !== 1'b0)
      $display("FAIL reset_decode: got run=%b go=%b want 0 0", running, game_over); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    start_btn = 1'b0;
    cycle();
  endtask

  task automatic test_start();
    start_btn = 1'b1;
    #1;
    n_checks++; if (state !== 2'd0) $display("FAIL start_pre_state: got %0d want 0", state); else n_pass++;
    cycle();
    n_checks++; if (state !== 2'd1) $display("FAIL start_state: got %0d want 1", state); else n_pass++;
    n_checks++; if (score !== 8'd0) $display("FAIL start_score: got %0d want 0", score); else n_pass++;
    n_checks++; if (running !== 1'b1) $display("FAIL start_running: got %b want 1", running); else n_pass++;
    tick = 1'b1; #1;
    n_checks++; if (move_en !== 1'b1) $display("FAIL start_move_en_hi: got %b want 1", move_en); else n_pass++;
    tick = 1'b0; #1;
    n_checks++; if (move_en !== 1'b0) $display("FAIL start_move_en_lo: got %b want 0", move_en); else n_pass++;
  endtask

  task automatic test_crash_to_over();
    bit reached;
    for (int i = 0; i < 3; i++) begin pass_mountain = 1'b1; cycle(); end
    pass_mountain = 1'b0; pass_lava = 1'b1; crash = 1'b1;
    cycle();
    pass_lava = 1'b0; crash = 1'b0;
    n_checks++; if (state !== 2'd2) $display("FAIL crash_state: got %0d want 2", state); else n_pass++;
    n_checks++; if (score !== 8'd3) $display("FAIL crash_score: got %0d want 3", score); else n_pass++;
    n_checks++; if (blink !== 1'b1) $display("FAIL crash_blink: got %b want 1", blink); else n_pass++;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      tick = 1'($urandom_range(0, 1));
      start_btn = 1'($urandom_range(0, 1));
      crash = 1'($urandom_range(0, 1));
      cycle();
      n_checks++; if (state !== 2'(m_state) || blink !== 1'(m_blink))
        $display("FAIL crash_walk: got st=%0d bl=%b want st=%0d bl=%0d", state, blink, m_state, m_blink);
      else n_pass++;
      n_checks++; if (game_over !== 1'b1) $display("FAIL crash_game_over: got %b want 1", game_over); else n_pass++;
      reached = (m_state == 3);
    end
    tick = 1'b0; crash = 1'b0;
    n_checks++; if (!reached) $display("FAIL crash_timeout: got state %0d want 3", state); else n_pass++;
    n_checks++; if (state !== 2'd3 || blink !== 1'b0)
      $display("FAIL over_state: got st=%0d bl=%b want 3 0", state, blink); else n_pass++;
    n_checks++; if (hiscore !== 8'(hi_expect(3)))
      $display("FAIL over_hiscore: got %0d want %0d", hiscore, hi_expect(3)); else n_pass++;
    start_btn = 1'b0; cycle();
    start_btn = 1'b1; cycle();
    n_checks++; if (state !== 2'd0 || score !== 8'd3)
      $display("FAIL over_to_idle: got st=%0d sc=%0d want 0 3", state, score); else n_pass++;
    start_btn = 1'b0; cycle();
    start_btn = 1'b1; cycle();
    n_checks++; if (state !== 2'd1 || score !== 8'd0)
      $display("FAIL restart: got st=%0d sc=%0d want 1 0", state, score); else n_pass++;
  endtask

  task automatic test_score();
    pass_mountain = 1'b1; pass_lava = 1'b1; cycle();
    pass_lava = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    pass_mountain = 1'b0; pass_lava = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    pass_lava = 1'b0;
    n_checks++; if (score !== 8'd12) $display("FAIL score_12: got %0d want 12", score); else n_pass++;
    n_checks++; if (score_bcd !== 12'(m_bcd))
      $display("FAIL score_bcd_lag: got %h want %h", score_bcd, 12'(m_bcd)); else n_pass++;
    cycle();
    n_checks++; if (score_bcd !== 12'h012) $display("FAIL score_bcd_12: got %h want 012", score_bcd); else n_pass++;
  endtask

  task automatic test_saturation();
    pass_mountain = 1'b1;
    for (int i = 0; i < 260; i++) begin
      cycle();
      n_checks++; if (score !== 8'(m_score))
        $display("FAIL sat_walk: got %0d want %0d", score, m_score); else n_pass++;
    end
    pass_mountain = 1'b0;
    cycle();
    n_checks++; if (score !== 8'd255) $display("FAIL sat_score: got %0d want 255", score); else n_pass++;
    n_checks++; if (score_bcd !== 12'h255) $display("FAIL sat_bcd: got %h want 255", score_bcd); else n_pass++;
  endtask

  task automatic test_async_reset();
    crash = 1'b1; cycle(); crash = 1'b0;
    tick = 1'b1; cycle(); cycle(); tick = 1'b0;
    n_checks++; if (state !== 2'd2) $display("FAIL areset_pre: got %0d want 2", state); else n_pass++;
    #2 start_btn = 1'b1; reset = 1'b1;
    #1;
    reset_model();
    n_checks++; if (state !== 2'd0 || score !== 8'd0 || blink !== 1'b0 || score_bcd !== 12'h000)
      $display("FAIL areset_async: got st=%0d sc=%0d bl=%b bcd=%h want 0 0 0 000",
               state, score, blink, score_bcd);
    else n_pass++;
    cycle(); cycle();
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (state !== 2'd0) $display("FAIL areset_held_start: got %0d want 0", state); else n_pass++;
    end
    start_btn = 1'b0; cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      tick          = ($urandom_range(0, 2) == 0);
      crash         = ($urandom_range(0, 29) == 0);
      pass_mountain = ($urandom_range(0, 3) == 0);
      pass_lava     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
      #1;
      n_checks++; if (move_en !== 1'(tick && m_state == 1))
        $display("FAIL rand_move_en: got %b want %0d", move_en, tick && m_state == 1); else n_pass++;
      cycle();
      n_checks++; if (state !== 2'(m_state) || score !== 8'(m_score) || blink !== 1'(m_blink))
        $display("FAIL rand_core: got st=%0d sc=%0d bl=%b want st=%0d sc=%0d bl=%0d",
                 state, score, blink, m_state, m_score, m_blink);
      else n_pass++;
      n_checks++; if (score_bcd !== 12'(m_bcd) || hiscore !== 8'(hi_expect(m_hi)))
        $display("FAIL rand_aux: got bcd=%h hi=%0d want bcd=%h hi=%0d",
                 score_bcd, hiscore, 12'(m_bcd), hi_expect(m_hi));
      else n_pass++;
      n_checks++; if (running !== 1'(m_state == 1) || game_over !== 1'(m_state >= 2))
        $display("FAIL rand_decode: got run=%b go=%b for state %0d", running, game_over, m_state);
      else n_pass++;
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        #1 reset_model();
        n_checks++; if (state !== 2'd0 || score !== 8'd0 || hiscore !== 8'd0)
          $display("FAIL rand_reset: got st=%0d sc=%0d hi=%0d want 0 0 0", state, score, hiscore);
        else n_pass++;
        #1 reset = 1'b0;
      end
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_start();
    test_crash_to_over();
    test_score();
    test_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
